// File: rtl/data_router_pkg.sv
// Shared types and helpers for the row bank buffer feeding the data-router bank mux.
package data_router_pkg;

    typedef logic [1:0] bank_idx_t;

    localparam int MAX_BANKS = 4;

    function automatic bank_idx_t next_bank(bank_idx_t b, int poy);
        return (int'(b) == poy - 1) ? 2'd0 : b + 2'd1;
    endfunction

endpackage

// File: rtl/bank_ptr_mod.sv
// Two-bit modulo-POY bank pointer with synchronous clear and increment enable.
module bank_ptr_mod
    import data_router_pkg::*;
#(
    parameter int POY = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      clr,
    input  logic      inc,
    output bank_idx_t ptr
);

    bank_idx_t ptr_q;
    bank_idx_t ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = next_bank(ptr_q, POY);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/row_bank_buffer.sv
// Rotating POY-bank row buffer; banks fill round-robin and are freed by rd_done.
// Optional stall counter output enabled by ROW_BANK_BUFFER_STALL_CNT_EN.
module row_bank_buffer
    import data_router_pkg::*;
#(
    parameter int DW   = 1,
    parameter int POY  = 3,
    parameter int BUFW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic [DW-1:0]   bank_data [POY][BUFW],
    output bank_idx_t       bank,
    output logic            rd_valid,
    input  logic            rd_done,
    output logic [2:0]      full_cnt,
    output logic            err
`ifdef ROW_BANK_BUFFER_STALL_CNT_EN
    ,
    output logic [15:0]     stall_cnt
`endif
);

    localparam int PW = $clog2(BUFW);

    if (POY < 1 || POY > MAX_BANKS) begin : g_bad_poy
        $error("row_bank_buffer: POY must be in 1..4");
    end
    if (BUFW < 2) begin : g_bad_bufw
        $error("row_bank_buffer: BUFW must be >= 2");
    end

    bank_idx_t            wr_bank;
    bank_idx_t            rd_bank;
    logic [MAX_BANKS-1:0] full_q, full_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [2:0]           full_cnt_q, full_cnt_d;
    logic                 err_q, err_d;
    logic [DW-1:0]        data_q [POY][BUFW];
    logic [DW-1:0]        data_d [POY][BUFW];
    logic                 accept;
    logic                 wr_last;
    logic                 rd_fire;

    assign in_ready = !full_q[wr_bank];
    assign rd_valid = full_q[rd_bank];
    assign accept   = !flush && in_valid && in_ready;
    assign wr_last  = accept && (wr_ptr_q == PW'(BUFW - 1));
    assign rd_fire  = !flush && rd_done && rd_valid;

    bank_ptr_mod #(.POY(POY)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (wr_last),
        .ptr   (wr_bank)
    );

    bank_ptr_mod #(.POY(POY)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (rd_fire),
        .ptr   (rd_bank)
    );

    always_comb begin
        data_d     = data_q;
        full_d     = full_q;
        wr_ptr_d   = wr_ptr_q;
        full_cnt_d = full_cnt_q;
        err_d      = err_q;
        for (int b = 0; b < POY; b++) begin
            for (int w = 0; w < BUFW; w++) begin
                if (accept && int'(wr_bank) == b && int'(wr_ptr_q) == w) begin
                    data_d[b][w] = in_data;
                end
            end
        end
        if (flush) begin
            full_d     = '0;
            wr_ptr_d   = '0;
            full_cnt_d = '0;
            err_d      = 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_last ? '0 : wr_ptr_q + 1'b1;
            end
            // A write can never complete into the bank being freed.
            if (rd_fire) full_d[rd_bank] = 1'b0;
            if (wr_last) full_d[wr_bank] = 1'b1;
            unique case ({wr_last, rd_fire})
                2'b10:   full_cnt_d = full_cnt_q + 3'd1;
                2'b01:   full_cnt_d = full_cnt_q - 3'd1;
                default: full_cnt_d = full_cnt_q;
            endcase
            if (rd_done && !rd_valid) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < POY; b++) begin
                for (int w = 0; w < BUFW; w++) begin
                    data_q[b][w] <= '0;
                end
            end
            full_q     <= '0;
            wr_ptr_q   <= '0;
            full_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            data_q     <= data_d;
            full_q     <= full_d;
            wr_ptr_q   <= wr_ptr_d;
            full_cnt_q <= full_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bank_data = data_q;
    assign bank      = rd_bank;
    assign full_cnt  = full_cnt_q;
    assign err       = err_q;

`ifdef ROW_BANK_BUFFER_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (flush) begin
            stall_d = '0;
        end else if (in_valid && !in_ready && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_row_bank_buffer.sv
// Directed plus randomized check of row_bank_buffer against a row-counting model.
module tb_row_bank_buffer;

    localparam int DW   = 8;
    localparam int POY  = 3;
    localparam int BUFW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [DW-1:0] bank_data [POY][BUFW];
    logic [1:0]    bank;
    logic          rd_valid;
    logic          rd_done;
    logic [2:0]    full_cnt;
    logic          err;
`ifdef ROW_BANK_BUFFER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    row_bank_buffer #(.DW(DW), .POY(POY), .BUFW(BUFW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bank_data (bank_data),
        .bank      (bank),
        .rd_valid  (rd_valid),
        .rd_done   (rd_done),
        .full_cnt  (full_cnt),
        .err       (err)
`ifdef ROW_BANK_BUFFER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: rows completed/consumed counters, word position, memory image.
    int            n_assert = 0;
    int            n_fail   = 0;
    int            rows_w;
    int            rows_r;
    int            words;
    bit            err_m;
    int            stall_m;
    logic [DW-1:0] mem [POY][BUFW];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string step);
        int occ;
        occ = rows_w - rows_r;
        chk({step, " in_ready"}, 32'(in_ready), 32'(occ < POY));
        chk({step, " rd_valid"}, 32'(rd_valid), 32'(occ > 0));
        chk({step, " bank"}, 32'(bank), 32'(rows_r % POY));
        chk({step, " full_cnt"}, 32'(full_cnt), 32'(occ));
        chk({step, " err"}, 32'(err), 32'(err_m));
        for (int b = 0; b < POY; b++) begin
            for (int w = 0; w < BUFW; w++) begin
                chk($sformatf("%s data[%0d][%0d]", step, b, w),
                    32'(bank_data[b][w]), 32'(mem[b][w]));
            end
        end
`ifdef ROW_BANK_BUFFER_STALL_CNT_EN
        chk({step, " stall_cnt"}, 32'(stall_cnt), 32'(stall_m));
`endif
    endtask

    task automatic model_clear(input bit clear_mem);
        rows_w  = 0;
        rows_r  = 0;
        words   = 0;
        err_m   = 1'b0;
        stall_m = 0;
        if (clear_mem) begin
            for (int b = 0; b < POY; b++)
                for (int w = 0; w < BUFW; w++)
                    mem[b][w] = '0;
        end
    endtask

    task automatic cycle(input string step, input bit v,
                         input logic [DW-1:0] d, input bit done,
                         input bit fl);
        int occ;
        bit acc;
        bit fire;
        in_valid = v;
        in_data  = d;
        rd_done  = done;
        flush    = fl;
        occ  = rows_w - rows_r;
        acc  = v && (occ < POY);
        fire = done && (occ > 0);
        @(posedge clk);
        if (fl) begin
            model_clear(1'b0);
        end else begin
            if (v && !acc && stall_m != 16'hFFFF) stall_m++;
            if (done && !fire) err_m = 1'b1;
            if (acc) begin
                mem[rows_w % POY][words] = d;
                words++;
                if (words == BUFW) begin
                    words = 0;
                    rows_w++;
                end
            end
            if (fire) rows_r++;
        end
        #1;
        in_valid = 1'b0;
        rd_done  = 1'b0;
        flush    = 1'b0;
        check_all(step);
    endtask

    task automatic do_reset(input string step);
        #2;
        rst_n = 1'b0;
        model_clear(1'b1);
        #1;
        check_all(step);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_row(input string step, input logic [DW-1:0] base);
        for (int i = 0; i < BUFW; i++) begin
            cycle(step, 1'b1, base + DW'(i), 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_done  = 1'b0;
        model_clear(1'b1);
        #3;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        write_row("fill1", 8'h10);
        chk("fill1 word3", 32'(bank_data[0][3]), 32'h13);

        write_row("fill2", 8'h20);
        write_row("fill3", 8'h30);
        cycle("blocked13", 1'b1, 8'h40, 1'b0, 1'b0);
        chk("blocked in_ready", 32'(in_ready), 32'd0);
        cycle("free0", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("free0 bank", 32'(bank), 32'd1);
        cycle("word13", 1'b1, 8'h40, 1'b0, 1'b0);
        chk("word13 lands", 32'(bank_data[0][0]), 32'h40);

        cycle("flush1", 1'b0, 8'h00, 1'b0, 1'b1);
        write_row("simul_b0", 8'h50);
        for (int i = 0; i < BUFW - 1; i++)
            cycle("simul_b1", 1'b1, 8'h60 + DW'(i), 1'b0, 1'b0);
        cycle("simul_edge", 1'b1, 8'h63, 1'b1, 1'b0);
        chk("simul full_cnt", 32'(full_cnt), 32'd1);

        cycle("flush2", 1'b0, 8'h00, 1'b0, 1'b1);
        cycle("err_set", 1'b0, 8'h00, 1'b1, 1'b0);
        cycle("err_hold", 1'b0, 8'h00, 1'b0, 1'b0);
        chk("err sticky", 32'(err), 32'd1);
        cycle("err_flush", 1'b0, 8'h00, 1'b0, 1'b1);

        for (int r = 0; r < 5; r++) begin
            write_row("wrap_wr", 8'h70 + DW'(r * 8));
            cycle("wrap_idle", 1'b0, 8'h00, 1'b0, 1'b0);
            cycle("wrap_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        end

        cycle("mid_w0", 1'b1, 8'h91, 1'b0, 1'b0);
        cycle("mid_w1", 1'b1, 8'h92, 1'b0, 1'b0);
        do_reset("midreset");
        write_row("after_rst", 8'hA0);
        chk("after_rst b0w0", 32'(bank_data[0][0]), 32'hA0);

`ifdef ROW_BANK_BUFFER_STALL_CNT_EN
        cycle("stall_flush", 1'b0, 8'h00, 1'b0, 1'b1);
        write_row("stall_f1", 8'hB0);
        write_row("stall_f2", 8'hB4);
        write_row("stall_f3", 8'hB8);
        for (int i = 0; i < 5; i++)
            cycle("stall_blk", 1'b1, 8'hEE, 1'b0, 1'b0);
        chk("stall five", 32'(stall_cnt), 32'd5);
`endif

        for (int i = 0; i < 400; i++) begin
            cycle("rand",
                  ($urandom_range(0, 9) < 7),
                  DW'($urandom),
                  ($urandom_range(0, 9) < 3),
                  ($urandom_range(0, 99) < 2));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
